// File: rtl/exec_alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : exec_alu_seq_if
// Description : Issue/result bundle between the register-file read side and
//               the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface exec_alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, in1, in2,
        input  result, result_hi, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, in1, in2,
        output result, result_hi, busy, done, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/exec_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : exec_alu_seq
// Description : Execute stage: single-cycle logic/arithmetic ops plus
//               bit-serial unsigned multiply and restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_alu_seq #(
    parameter int WIDTH = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    exec_alu_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_slt  = 4'd5;
    localparam logic [3:0] c_op_sll  = 4'd6;
    localparam logic [3:0] c_op_srl  = 4'd7;
    localparam logic [3:0] c_op_mulu = 4'd8;
    localparam logic [3:0] c_op_divu = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_hi;       // MUL: partial product high / DIV: remainder
    logic [WIDTH-1:0]   r_lo;       // MUL: multiplier shifting out / DIV: quotient shifting in
    logic [WIDTH-1:0]   r_b;        // multiplicand or divisor
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_busy;
    logic               r_done;
    logic               r_div_by_zero;

    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;

    always_comb begin
        w_alu = '0;
        case (bus.op)
            c_op_add: w_alu = bus.in1 + bus.in2;
            c_op_sub: w_alu = bus.in1 - bus.in2;
            c_op_and: w_alu = bus.in1 & bus.in2;
            c_op_or:  w_alu = bus.in1 | bus.in2;
            c_op_xor: w_alu = bus.in1 ^ bus.in2;
            c_op_slt: w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
            c_op_sll: w_alu = bus.in1 << bus.in2[4:0];
            c_op_srl: w_alu = bus.in1 >> bus.in2[4:0];
            default:  w_alu = '0;
        endcase
    end

    // One shift-add step: conditionally add, then shift {carry, hi, lo} right.
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_mul_hi  = w_mul_sum[WIDTH:1];
        w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end

    // One restoring step: the remainder stays below the divisor, so the
    // shifted value needs one extra bit but the difference fits in WIDTH.
    always_comb begin
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
        w_div_hi    = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_b) : w_div_shift[WIDTH-1:0];
        w_div_lo    = {r_lo[WIDTH-2:0], w_div_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_b           <= '0;
            r_result      <= '0;
            r_result_hi   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_div_by_zero <= 1'b0;
                        if (bus.op == c_op_mulu) begin
                            r_hi    <= '0;
                            r_lo    <= bus.in2;
                            r_b     <= bus.in1;
                            r_count <= CNT_W'(WIDTH);
                            r_busy  <= 1'b1;
                            r_state <= ST_MUL;
                        end else if (bus.op == c_op_divu && bus.in2 != '0) begin
                            r_hi    <= '0;
                            r_lo    <= bus.in1;
                            r_b     <= bus.in2;
                            r_count <= CNT_W'(WIDTH);
                            r_busy  <= 1'b1;
                            r_state <= ST_DIV;
                        end else if (bus.op == c_op_divu) begin
                            r_result      <= '1;
                            r_result_hi   <= bus.in1;
                            r_div_by_zero <= 1'b1;
                            r_done        <= 1'b1;
                        end else begin
                            r_result    <= w_alu;
                            r_result_hi <= '0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    r_hi    <= w_mul_hi;
                    r_lo    <= w_mul_lo;
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_result    <= w_mul_lo;
                        r_result_hi <= w_mul_hi;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    r_hi    <= w_div_hi;
                    r_lo    <= w_div_lo;
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_result    <= w_div_lo;
                        r_result_hi <= w_div_hi;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result      = r_result;
    assign bus.result_hi   = r_result_hi;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_div_by_zero;
endmodule
`default_nettype wire

// File: tb/tb_exec_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_alu_seq
// Description : Self-checking bench for exec_alu_seq against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_alu_seq;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    exec_alu_seq_if #(.WIDTH(WIDTH)) bus ();

    exec_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] lo, output logic [31:0] hi,
                                      output logic dbz, output int edges);
        logic [63:0] p;
        lo = '0; hi = '0; dbz = 1'b0; edges = 0;
        case (op)
            4'd0: lo = a + b;
            4'd1: lo = a - b;
            4'd2: lo = a & b;
            4'd3: lo = a | b;
            4'd4: lo = a ^ b;
            4'd5: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: lo = a << b[4:0];
            4'd7: lo = a >> b[4:0];
            4'd8: begin
                p = {32'd0, a} * {32'd0, b};
                lo = p[31:0]; hi = p[63:32]; edges = WIDTH;
            end
            4'd9: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF; hi = a; dbz = 1'b1;
                end else begin
                    lo = a / b; hi = a % b; edges = WIDTH;
                end
            end
            default: ;
        endcase
    endfunction

    // Issues one op; returns after the accepting edge with start dropped.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.in1 = a; bus.in2 = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in1 = $urandom; bus.in2 = $urandom;
    endtask

    // Counts edges after acceptance until done, and busy samples on the way.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_cnt);
        issue(op, a, b);
        edges = 0; busy_cnt = 0;
        while (!bus.done && edges < 40) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.in1 = '0; bus.in2 = '0;
        #1;
        n_total++; if (bus.result !== 32'd0) $display("FAIL reset_result: got %h expected 0", bus.result); else n_pass++;
        n_total++; if (bus.result_hi !== 32'd0) $display("FAIL reset_result_hi: got %h expected 0", bus.result_hi); else n_pass++;
        n_total++; if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.div_by_zero}); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_idle_done: got %b expected 0", bus.done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int seen_busy = 0;
        issue(4'd0, 32'd5, 32'd3);
        n_total++; if (bus.result !== 32'h0000_0008) $display("FAIL b2b_add_result: got %h expected 00000008", bus.result); else n_pass++;
        n_total++; if (bus.done !== 1'b1) $display("FAIL b2b_add_done: got %b expected 1", bus.done); else n_pass++;
        if (bus.busy) seen_busy++;
        issue(4'd1, 32'd1, 32'd5);
        n_total++; if (bus.result !== 32'hFFFF_FFFC) $display("FAIL b2b_sub_result: got %h expected fffffffc", bus.result); else n_pass++;
        n_total++; if (bus.done !== 1'b1) $display("FAIL b2b_sub_done: got %b expected 1", bus.done); else n_pass++;
        if (bus.busy) seen_busy++;
        @(posedge clk); #1;
        n_total++; if (bus.done !== 1'b0) $display("FAIL b2b_done_drop: got %b expected 0", bus.done); else n_pass++;
        n_total++; if (seen_busy != 0) $display("FAIL b2b_busy: got %0d busy samples expected 0", seen_busy); else n_pass++;
    endtask

    task automatic test_shift_compare();
        issue(4'd5, 32'hFFFF_FFFF, 32'd1);
        n_total++; if (bus.result !== 32'd1) $display("FAIL slt_neg: got %h expected 1", bus.result); else n_pass++;
        issue(4'd7, 32'h8000_0000, 32'd31);
        n_total++; if (bus.result !== 32'd1) $display("FAIL srl_31: got %h expected 1", bus.result); else n_pass++;
        issue(4'd6, 32'd1, 32'h0000_0024);
        n_total++; if (bus.result !== 32'h10) $display("FAIL sll_mask: got %h expected 10", bus.result); else n_pass++;
        n_total++; if (bus.result_hi !== 32'd0) $display("FAIL sll_hi: got %h expected 0", bus.result_hi); else n_pass++;
    endtask

    task automatic test_mulu();
        int edges = 0;
        int busy_cnt = 0;
        logic [31:0] prev;
        prev = bus.result;
        issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        while (edges < 40) begin
            if (bus.done) break;
            if (bus.busy) busy_cnt++;
            if (edges == 5) begin
                n_total++; if (bus.result !== prev) $display("FAIL mulu_hold: got %h expected %h", bus.result, prev); else n_pass++;
            end
            if (edges == 9) begin
                @(negedge clk);
                bus.start = 1'b1; bus.op = 4'd0; bus.in1 = 32'd1; bus.in2 = 32'd1;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            edges++;
        end
        n_total++; if (edges != 32) $display("FAIL mulu_latency: got %0d expected 32", edges); else n_pass++;
        n_total++; if (busy_cnt != 32) $display("FAIL mulu_busy_cycles: got %0d expected 32", busy_cnt); else n_pass++;
        n_total++; if (bus.result !== 32'h0000_0001) $display("FAIL mulu_lo: got %h expected 00000001", bus.result); else n_pass++;
        n_total++; if (bus.result_hi !== 32'hFFFF_FFFE) $display("FAIL mulu_hi: got %h expected fffffffe", bus.result_hi); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL mulu_busy_clear: got %b expected 0", bus.busy); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus.done !== 1'b0) $display("FAIL mulu_no_extra_done: got %b expected 0", bus.done); else n_pass++;
        n_total++; if (bus.result !== 32'h0000_0001) $display("FAIL mulu_result_held: got %h expected 00000001", bus.result); else n_pass++;
    endtask

    task automatic test_divu();
        int edges, busy_cnt;
        run_op(4'd9, 32'd7, 32'd3, edges, busy_cnt);
        n_total++; if (edges != 32) $display("FAIL divu_latency: got %0d expected 32", edges); else n_pass++;
        n_total++; if (bus.result !== 32'd2 || bus.result_hi !== 32'd1) $display("FAIL divu_7_3: got q=%h r=%h expected q=2 r=1", bus.result, bus.result_hi); else n_pass++;
        run_op(4'd9, 32'd7, 32'd0, edges, busy_cnt);
        n_total++; if (edges != 0) $display("FAIL div0_latency: got %0d extra edges expected 0", edges); else n_pass++;
        n_total++; if (bus.result !== 32'hFFFF_FFFF || bus.result_hi !== 32'd7) $display("FAIL div0_values: got q=%h r=%h expected q=ffffffff r=7", bus.result, bus.result_hi); else n_pass++;
        n_total++; if (bus.div_by_zero !== 1'b1) $display("FAIL div0_flag: got %b expected 1", bus.div_by_zero); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus.div_by_zero !== 1'b1) $display("FAIL div0_flag_hold: got %b expected 1", bus.div_by_zero); else n_pass++;
        issue(4'd0, 32'd2, 32'd2);
        n_total++; if (bus.div_by_zero !== 1'b0) $display("FAIL div0_flag_clear: got %b expected 0", bus.div_by_zero); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int edges, busy_cnt;
        int done_seen = 0;
        issue(4'd8, 32'd3, 32'd5);
        repeat (9) begin @(posedge clk); #1; end
        #2; rst = 1'b1; #1;
        n_total++; if (bus.result !== 32'd0 || bus.result_hi !== 32'd0) $display("FAIL rst_mid_values: got %h/%h expected 0/0", bus.result, bus.result_hi); else n_pass++;
        n_total++; if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) $display("FAIL rst_mid_flags: got %b expected 000", {bus.busy, bus.done, bus.div_by_zero}); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_seen++;
        end
        n_total++; if (done_seen != 0) $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", done_seen); else n_pass++;
        run_op(4'd8, 32'd6, 32'd7, edges, busy_cnt);
        n_total++; if (edges != 32) $display("FAIL mul_6x7_latency: got %0d expected 32", edges); else n_pass++;
        n_total++; if (bus.result !== 32'd42 || bus.result_hi !== 32'd0) $display("FAIL mul_6x7: got %h/%h expected 0000002a/0", bus.result, bus.result_hi); else n_pass++;
    endtask

    task automatic test_undefined_op();
        issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
        n_total++; if (bus.done !== 1'b1) $display("FAIL op12_done: got %b expected 1", bus.done); else n_pass++;
        n_total++; if (bus.result !== 32'd0 || bus.result_hi !== 32'd0) $display("FAIL op12_values: got %h/%h expected 0/0", bus.result, bus.result_hi); else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b, exp_lo, exp_hi;
        logic        exp_dbz;
        int          exp_edges, edges, busy_cnt;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            ref_model(op, a, b, exp_lo, exp_hi, exp_dbz, exp_edges);
            run_op(op, a, b, edges, busy_cnt);
            n_total++; if (edges != exp_edges || busy_cnt != exp_edges) $display("FAIL rand_timing op=%0d: got edges=%0d busy=%0d expected %0d", op, edges, busy_cnt, exp_edges); else n_pass++;
            n_total++; if (bus.result !== exp_lo || bus.result_hi !== exp_hi) $display("FAIL rand_value op=%0d a=%h b=%h: got %h/%h expected %h/%h", op, a, b, bus.result, bus.result_hi, exp_lo, exp_hi); else n_pass++;
            n_total++; if (bus.div_by_zero !== exp_dbz) $display("FAIL rand_dbz op=%0d: got %b expected %b", op, bus.div_by_zero, exp_dbz); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shift_compare();
        test_mulu();
        test_divu();
        test_reset_mid_op();
        test_undefined_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
